// File: rtl/k_dsp_pkg.sv
// Shared types and default geometry for the K_DSP image pipeline.
// Used by the raster address generator (optional border outputs: K_ADDGEN_BORDER_EN).
package k_dsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } k_addgen_state_t;

    localparam int K_IMG_COLS = 240;
    localparam int K_IMG_ROWS = 240;

endpackage

// File: rtl/k_wrap_counter.sv
// Modulo-(MAX+1) counter: advances on inc, returns to zero on clr or after MAX.
// wrap flags the increment that rolls the count over.
module k_wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_r;

    assign count = count_r;
    assign wrap  = inc & (count_r == MAX_V);

    // count register: clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc) begin
            count_r <= wrap ? {W{1'b0}} : count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/k_raster_addgen.sv
// Row-major COLS x ROWS raster address generator with valid/ready output,
// start/abort control and line/frame markers. Border flags: K_ADDGEN_BORDER_EN.
module k_raster_addgen
    import k_dsp_pkg::*;
#(
    parameter int COLS   = K_IMG_COLS,
    parameter int ROWS   = K_IMG_ROWS,
    parameter int COL_W  = $clog2(COLS),
    parameter int ROW_W  = $clog2(ROWS),
    parameter int ADDR_W = $clog2(COLS * ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              line_last,
    output logic              frame_last,
    output logic              busy,
    output logic              done
`ifdef K_ADDGEN_BORDER_EN
    ,
    output logic              edge_top,
    output logic              edge_bottom,
    output logic              edge_left,
    output logic              edge_right
`endif
);

    localparam logic [COL_W-1:0] COL_PEN  = COL_W'(COLS - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    k_addgen_state_t state_r, state_nxt_s;

    logic              out_valid_r, busy_r, done_r;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic              line_last_r, line_last_nxt_s;
    logic              frame_last_r, frame_last_nxt_s;
    logic [COL_W-1:0]  col_s;
    logic [ROW_W-1:0]  row_s;
    logic              clr_s, adv_s, col_wrap_s, row_wrap_s;

    // abort beats a simultaneous handshake, so the beat is not counted
    assign adv_s = out_valid_r & out_ready & ~abort;
    assign clr_s = ((state_r == IDLE) & start) | ((state_r == RUN) & abort);

    k_wrap_counter #(.MAX(COLS - 1), .W(COL_W)) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (adv_s),
        .clr   (clr_s),
        .count (col_s),
        .wrap  (col_wrap_s)
    );

    k_wrap_counter #(.MAX(ROWS - 1), .W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (col_wrap_s),
        .clr   (clr_s),
        .count (row_s),
        .wrap  (row_wrap_s)
    );

    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign col        = col_s;
    assign row        = row_s;
    assign addr       = addr_r;
    assign line_last  = line_last_r;
    assign frame_last = frame_last_r;

    // next-state logic; row_wrap_s marks acceptance of the final beat
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (row_wrap_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // markers describe the beat that will be presented after this edge
    always_comb begin
        addr_nxt_s       = addr_r;
        line_last_nxt_s  = line_last_r;
        frame_last_nxt_s = frame_last_r;
        if (clr_s) begin
            addr_nxt_s       = {ADDR_W{1'b0}};
            line_last_nxt_s  = 1'b0;
            frame_last_nxt_s = 1'b0;
        end else if (adv_s) begin
            addr_nxt_s       = row_wrap_s ? {ADDR_W{1'b0}} : addr_r + ADDR_W'(1);
            line_last_nxt_s  = (col_s == COL_PEN);
            frame_last_nxt_s = (col_s == COL_PEN) & (row_s == ROW_LAST);
        end else begin
            addr_nxt_s       = addr_r;
            line_last_nxt_s  = line_last_r;
            frame_last_nxt_s = frame_last_r;
        end
    end

    // state, status and beat registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            line_last_r  <= 1'b0;
            frame_last_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            out_valid_r  <= (state_nxt_s == RUN);
            busy_r       <= (state_nxt_s != IDLE);
            done_r       <= (state_nxt_s == DONE);
            addr_r       <= addr_nxt_s;
            line_last_r  <= line_last_nxt_s;
            frame_last_r <= frame_last_nxt_s;
        end
    end

`ifdef K_ADDGEN_BORDER_EN
    localparam logic [ROW_W-1:0] ROW_PEN = ROW_W'(ROWS - 2);

    logic edge_top_r, edge_bottom_r, edge_left_r, edge_right_r;
    logic edge_top_nxt_s, edge_bottom_nxt_s, edge_left_nxt_s, edge_right_nxt_s;

    assign edge_top    = edge_top_r;
    assign edge_bottom = edge_bottom_r;
    assign edge_left   = edge_left_r;
    assign edge_right  = edge_right_r;

    // border flags for the next presented beat, forced low while not valid
    always_comb begin
        edge_top_nxt_s    = edge_top_r;
        edge_bottom_nxt_s = edge_bottom_r;
        edge_left_nxt_s   = edge_left_r;
        edge_right_nxt_s  = edge_right_r;
        if (state_nxt_s != RUN) begin
            edge_top_nxt_s    = 1'b0;
            edge_bottom_nxt_s = 1'b0;
            edge_left_nxt_s   = 1'b0;
            edge_right_nxt_s  = 1'b0;
        end else if (state_r == IDLE) begin
            edge_top_nxt_s    = 1'b1;
            edge_bottom_nxt_s = 1'b0;
            edge_left_nxt_s   = 1'b1;
            edge_right_nxt_s  = 1'b0;
        end else if (adv_s) begin
            edge_top_nxt_s    = (row_s == {ROW_W{1'b0}}) & ~line_last_r;
            edge_bottom_nxt_s = (row_s == ROW_LAST) | (line_last_r & (row_s == ROW_PEN));
            edge_left_nxt_s   = line_last_r;
            edge_right_nxt_s  = line_last_nxt_s;
        end else begin
            edge_top_nxt_s    = edge_top_r;
            edge_bottom_nxt_s = edge_bottom_r;
            edge_left_nxt_s   = edge_left_r;
            edge_right_nxt_s  = edge_right_r;
        end
    end

    // border flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_top_r    <= 1'b0;
            edge_bottom_r <= 1'b0;
            edge_left_r   <= 1'b0;
            edge_right_r  <= 1'b0;
        end else begin
            edge_top_r    <= edge_top_nxt_s;
            edge_bottom_r <= edge_bottom_nxt_s;
            edge_left_r   <= edge_left_nxt_s;
            edge_right_r  <= edge_right_nxt_s;
        end
    end
`endif

endmodule

// File: tb/tb_k_raster_addgen.sv
// Directed bench for k_raster_addgen on a 4x3 frame: streaming, stalls,
// abort, ignored starts and async reset (border flags when K_ADDGEN_BORDER_EN).
module tb_k_raster_addgen;

    localparam int COLS = 4;
    localparam int ROWS = 3;

    logic       clk, rst_n, start, abort, out_ready;
    logic       out_valid, line_last, frame_last, busy, done;
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] addr;
`ifdef K_ADDGEN_BORDER_EN
    logic       edge_top, edge_bottom, edge_left, edge_right;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    k_raster_addgen #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .col        (col),
        .row        (row),
        .addr       (addr),
        .line_last  (line_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
`ifdef K_ADDGEN_BORDER_EN
        ,
        .edge_top    (edge_top),
        .edge_bottom (edge_bottom),
        .edge_left   (edge_left),
        .edge_right  (edge_right)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_addr"}, 32'(addr), 32'd0);
        check_eq({tag, "_col"}, 32'(col), 32'd0);
        check_eq({tag, "_row"}, 32'(row), 32'd0);
    endtask

    task automatic check_beat(input int i);
        check_eq("beat_valid", 32'(out_valid), 32'd1);
        check_eq("beat_addr", 32'(addr), 32'(i));
        check_eq("beat_col", 32'(col), 32'(i % COLS));
        check_eq("beat_row", 32'(row), 32'(i / COLS));
        check_eq("beat_line_last", 32'(line_last), 32'(i % COLS == COLS - 1));
        check_eq("beat_frame_last", 32'(frame_last), 32'(i == COLS * ROWS - 1));
        check_eq("beat_done", 32'(done), 32'd0);
`ifdef K_ADDGEN_BORDER_EN
        check_eq("edge_top", 32'(edge_top), 32'(i < COLS));
        check_eq("edge_bottom", 32'(edge_bottom), 32'(i >= COLS * (ROWS - 1)));
        check_eq("edge_left", 32'(edge_left), 32'(i % COLS == 0));
        check_eq("edge_right", 32'(edge_right), 32'(i % COLS == COLS - 1));
`endif
    endtask

    // full frame; optional 3-cycle stall at addr 5 and stray start pulses
    task automatic run_frame(input bit stall, input bit poke_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < COLS * ROWS; i++) begin
            if (stall && i == 5) begin
                out_ready = 1'b0;
                repeat (3) begin
                    check_beat(5);
                    tick();
                end
                out_ready = 1'b1;
            end
            check_beat(i);
            start = poke_start && (i == 3);
            tick();
            start = 1'b0;
        end
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_valid", 32'(out_valid), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd1);
        start = poke_start;
        tick();
        start = 1'b0;
        check_idle("post_done");
        tick();
        check_idle("post_done2");
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        check_eq("reset_line_last", 32'(line_last), 32'd0);
        check_eq("reset_frame_last", 32'(frame_last), 32'd0);
        rst_n = 1'b1;
        tick();
        check_idle("after_release");

        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        run_frame(1'b0, 1'b1);

        // abort at addr 7 with a simultaneous handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_abort_addr", 32'(addr), 32'd7);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        tick();
        check_idle("abort2");
        run_frame(1'b0, 1'b0);

        // asynchronous reset at addr 9
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("pre_reset_addr", 32'(addr), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        check_eq("async_line_last", 32'(line_last), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_idle("idle_after_reset");
        end
        run_frame(1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
